vrased_reset_ctl: RTL and testbench
===================================

Name: vrased_reset_ctl

Overview:
- Downstream consumer of the per-monitor `reset` outputs (DMA key-access monitor, CPU key-access monitor, atomicity monitor, etc.).
- Merges N violation requests into one stretched system reset for the openMSP430 core.
- Records which monitors fired in a sticky cause register and counts reset events.
- Prevents a monitor's lingering `reset` level (held until PC reaches the reset handler) from retriggering endless resets.

Parameters:
- N_SRC, 4: number of monitor reset inputs.
- HOLD_CYCLES, 4: minimum cycles `sys_reset` stays high per event (≥1).
- RECOVER_TIMEOUT, 64: cycles allowed in RECOVER for all sources to drop (≥1).
- CNT_W, 8: width of the reset event counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- viol  in  N_SRC  per-monitor reset requests; level, active-high; bit i = monitor i.
- clr_cause  in  1  one-cycle pulse; clears `cause`.
- sys_reset  out  1  reset to CPU core, active-high, registered.
- cause  out  N_SRC  sticky record of sources that triggered resets.
- viol_cnt  out  CNT_W  saturating count of entries into ASSERT from RUN/RECOVER.
- busy  out  1  high whenever state != RUN.

Behaviour:
- States: ASSERT, RECOVER, RUN. All outputs and state are registered.
- On `rst`:
  - state = ASSERT, hold counter = 0, timeout counter = 0.
  - sys_reset = 1, cause = 0, viol_cnt = 0, busy = 1.
  - Power-up is fail-safe: reset asserted, same as monitors starting in KILL.
- ASSERT:
  - sys_reset = 1; hold counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1, move to RECOVER next cycle.
  - Total `sys_reset` high time is exactly HOLD_CYCLES cycles per entry.
  - `viol` is ignored; no retrigger and no extension.
- RECOVER:
  - sys_reset = 0; the core runs from the reset handler so monitors can return to RUN.
  - If viol == 0, go to RUN next cycle.
  - Else, when the timeout counter reaches RECOVER_TIMEOUT-1, go to ASSERT, OR `viol` into `cause`, and increment `viol_cnt`.
  - Timeout counter clears on entry to RECOVER.
- RUN:
  - sys_reset = 0.
  - Any bit of `viol` high: next cycle go to ASSERT, set sys_reset = 1, OR `viol` into `cause`, increment `viol_cnt`.
  - Response latency from a `viol` rise in RUN to `sys_reset` high is 1 cycle.
- cause:
  - Bits set only on the transitions into ASSERT named above.
  - Power-on entry via `rst` does not set bits.
  - `clr_cause` zeroes `cause`. If a capture happens in the same cycle, the cleared value is ORed with the new bits, so new bits survive.
- viol_cnt:
  - Increments by 1 per event and saturates at all-ones; never wraps.
  - Not cleared by `clr_cause`; only `rst` clears it.
- Simultaneous multi-bit `viol`: one event, one count increment, all high bits recorded.
- `rst` mid-ASSERT or mid-RECOVER: immediate return to the reset state above; `cause` is lost.
- busy = (state != RUN).

Optional Feature:
- Macro: VRASED_VIOL_CNT_EN.
- Defined: `viol_cnt` is implemented as specified.
- Undefined:
  - No counter register is synthesised; `viol_cnt` is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset release → sys_reset=1 for 4 cycles, then RECOVER; with viol=0, RUN on cycle 6; cause=0, viol_cnt=0.
- In RUN, viol=4'b0001 for 1 cycle → sys_reset high the next cycle for exactly 4 cycles; cause=4'b0001; viol_cnt=1; back in RUN after viol clears.
- In RUN, viol=4'b0101 held until 10 cycles into RECOVER → single event; cause=4'b0101; viol_cnt=1; no retrigger; RUN reached.
- viol=4'b0010 held permanently → ASSERT (4 cycles) / RECOVER (64 cycles) loop; viol_cnt increments once per loop; with CNT_W=2 it saturates at 3.
- clr_cause pulsed in the same cycle as a RUN→ASSERT capture of 4'b1000, with cause previously 4'b0001 → cause=4'b1000.
- rst asserted during the 2nd ASSERT cycle → all outputs return to reset values; sys_reset stays high; cause=0.

Source files
------------

// File: rtl/vrased_reset_ctl.sv
// vrased_reset_ctl: merges monitor reset requests into one stretched core reset, with a sticky cause register
// and a reset-event counter. The counter exists only when VRASED_VIOL_CNT_EN is defined; otherwise viol_cnt reads 0.
// After each reset pulse the core gets a RECOVER window, so that a request still held from the previous event does
// not start a new reset at once.
module vrased_reset_ctl #(
    parameter int N_SRC           = 4,
    parameter int HOLD_CYCLES     = 4,
    parameter int RECOVER_TIMEOUT = 64,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] viol,
    input  logic             clr_cause,
    output logic             sys_reset,
    output logic [N_SRC-1:0] cause,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             busy
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = RECOVER_TIMEOUT > 1 ? $clog2(RECOVER_TIMEOUT) : 1;

    typedef enum logic [1:0] {ASSERT, RECOVER, RUN} state_t;

    state_t           state_q;
    logic [HW-1:0]    hold_q;
    logic [TW-1:0]    tmo_q;
    logic             sys_reset_q, busy_q;
    logic [N_SRC-1:0] cause_q, cause_d;
    logic             capture;

    // A capture is any entry into ASSERT other than through rst; a clear and a capture in one cycle keep the new bits
    always_comb begin
        capture = (state_q == RUN) ? |viol
                : (state_q == RECOVER) && |viol && tmo_q == TW'(RECOVER_TIMEOUT - 1);
        cause_d = (clr_cause ? '0 : cause_q) | (capture ? viol : '0);
    end

    // Main sequencer: hold the reset for a fixed time, then allow the sources a bounded time to drop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ASSERT;
            hold_q      <= '0;
            tmo_q       <= '0;
            sys_reset_q <= 1'b1;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        state_q     <= RECOVER;
                        tmo_q       <= '0;
                        sys_reset_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RECOVER: begin
                    if (viol == '0) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else if (capture) begin
                        state_q     <= ASSERT;
                        hold_q      <= '0;
                        sys_reset_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                RUN: begin
                    if (capture) begin
                        state_q     <= ASSERT;
                        hold_q      <= '0;
                        sys_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ASSERT;
                    hold_q      <= '0;
                    sys_reset_q <= 1'b1;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    // Sticky record of which sources caused resets; only rst or clr_cause clears it
    always_ff @(posedge clk) begin
        if (rst) cause_q <= '0;
        else cause_q <= cause_d;
    end

`ifdef VRASED_VIOL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The event count saturates at all-ones and does not wrap
    always_comb cnt_d = (capture && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    // The event counter is cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign viol_cnt = cnt_q;
`else
    assign viol_cnt = '0;
`endif

    assign sys_reset = sys_reset_q;
    assign busy      = busy_q;
    assign cause     = cause_q;
endmodule

// File: tb/tb_vrased_reset_ctl.sv
// tb_vrased_reset_ctl: testbench for vrased_reset_ctl. It compares the outputs with a cycle-count reference model.
// Expected viol_cnt is the event count when VRASED_VIOL_CNT_EN is defined, and 0 when it is not.
module tb_vrased_reset_ctl;
    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int TO   = 64;
    localparam int CW   = 2;
`ifdef VRASED_VIOL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b1, clr_cause = 1'b0;
    logic [N-1:0] viol = '0;
    logic         sys_reset, busy;
    logic [N-1:0] cause;
    logic [CW-1:0] viol_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: m_left counts the samples that still show reset high.
    // m_age counts the cycles spent in recovery; -1 means not recovering.
    int           m_left = 0;
    int           m_age  = -1;
    int           m_cnt  = 0;
    logic [N-1:0] m_cause = '0;

    vrased_reset_ctl #(
        .N_SRC(N), .HOLD_CYCLES(HOLD), .RECOVER_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .viol(viol), .clr_cause(clr_cause),
        .sys_reset(sys_reset), .cause(cause), .viol_cnt(viol_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [N-1:0] v, input logic c, input logic r);
        bit ev;
        ev = 1'b0;
        if (r) begin
            m_left = HOLD;
            m_age = -1;
            m_cause = '0;
            m_cnt = 0;
            return;
        end
        if (m_left > 1) m_left--;
        else if (m_left == 1) begin
            m_left = 0;
            m_age = 0;
        end else if (m_age >= 0) begin
            if (v == '0) m_age = -1;
            else if (m_age == TO - 1) ev = 1'b1;
            else m_age++;
        end else ev = (v != '0);
        m_cause = (c ? '0 : m_cause) | (ev ? v : '0);
        if (ev) begin
            m_left = HOLD;
            m_age = -1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
    endtask

    function automatic logic exp_sys();
        return m_left > 0;
    endfunction

    function automatic logic exp_busy();
        return m_left > 0 || m_age >= 0;
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
        return CNT_EN ? CW'(m_cnt) : '0;
    endfunction

    task automatic tick(input logic [N-1:0] v, input logic c, input logic r);
        viol = v;
        clr_cause = c;
        rst = r;
        @(posedge clk);
        model_step(v, c, r);
        #1;
    endtask

    task automatic do_reset();
        tick('0, 1'b0, 1'b1);
        repeat (HOLD + 1) tick('0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int n_hi, run_at;
        run_at = 0;
        tick('0, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        checks++;
        if (sys_reset !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl: sys_reset=%b busy=%b, expected 1 1", sys_reset, busy);
        end
        checks++;
        if (cause !== '0 || viol_cnt !== '0) begin
            errors++;
            $display("FAIL reset_regs: cause=%b viol_cnt=%0d, expected 0 0", cause, viol_cnt);
        end
        n_hi = 1;
        for (int i = 2; i <= 10; i++) begin
            tick('0, 1'b0, 1'b0);
            n_hi += int'(sys_reset);
            if (run_at == 0 && busy === 1'b0) run_at = i;
            checks++;
            if (sys_reset !== exp_sys() || busy !== exp_busy()) begin
                errors++;
                $display("FAIL reset_seq cycle %0d: sys_reset=%b busy=%b, expected %b %b",
                         i, sys_reset, busy, exp_sys(), exp_busy());
            end
        end
        checks++;
        if (n_hi != HOLD) begin
            errors++;
            $display("FAIL reset_hold: high for %0d cycles, expected %0d", n_hi, HOLD);
        end
        checks++;
        if (run_at != HOLD + 2) begin
            errors++;
            $display("FAIL reset_run_cycle: RUN at cycle %0d, expected %0d", run_at, HOLD + 2);
        end
    endtask

    task automatic test_single();
        int n_hi;
        do_reset();
        tick(4'b0001, 1'b0, 1'b0);
        checks++;
        if (sys_reset !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: sys_reset=%b, expected 1", sys_reset);
        end
        n_hi = 1;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            tick('0, 1'b0, 1'b0);
            n_hi += int'(sys_reset);
        end
        checks++;
        if (n_hi != HOLD) begin
            errors++;
            $display("FAIL single_hold: high for %0d cycles, expected %0d", n_hi, HOLD);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_run: busy=%b, expected 0", busy);
        end
        checks++;
        if (cause !== 4'b0001) begin
            errors++;
            $display("FAIL single_cause: cause=%b, expected 0001", cause);
        end
        checks++;
        if (viol_cnt !== CW'(CNT_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL single_cnt: viol_cnt=%0d, expected %0d", viol_cnt, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_multi_hold();
        int rises;
        logic prev;
        rises = 0;
        do_reset();
        prev = sys_reset;
        repeat (HOLD + 11) begin
            tick(4'b0101, 1'b0, 1'b0);
            if (sys_reset === 1'b1 && prev === 1'b0) rises++;
            prev = sys_reset;
        end
        checks++;
        if (sys_reset !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL multi_recover: sys_reset=%b busy=%b, expected 0 1", sys_reset, busy);
        end
        tick('0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL multi_run: busy=%b, expected 0", busy);
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL multi_events: %0d reset pulses, expected 1", rises);
        end
        checks++;
        if (cause !== 4'b0101) begin
            errors++;
            $display("FAIL multi_cause: cause=%b, expected 0101", cause);
        end
        checks++;
        if (viol_cnt !== CW'(CNT_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL multi_cnt: viol_cnt=%0d, expected %0d", viol_cnt, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_permanent();
        int rises, last;
        logic prev;
        rises = 0;
        last = -1;
        do_reset();
        prev = sys_reset;
        for (int i = 0; i < 5 * (HOLD + TO); i++) begin
            tick(4'b0010, 1'b0, 1'b0);
            if (sys_reset === 1'b1 && prev === 1'b0) begin
                rises++;
                checks++;
                if (viol_cnt !== CW'(CNT_EN ? (rises < 3 ? rises : 3) : 0)) begin
                    errors++;
                    $display("FAIL perm_cnt event %0d: viol_cnt=%0d, expected %0d",
                             rises, viol_cnt, CNT_EN ? (rises < 3 ? rises : 3) : 0);
                end
                if (last >= 0) begin
                    checks++;
                    if (i - last != HOLD + TO) begin
                        errors++;
                        $display("FAIL perm_period: %0d cycles between pulses, expected %0d", i - last, HOLD + TO);
                    end
                end
                last = i;
            end
            prev = sys_reset;
        end
        checks++;
        if (rises != 5) begin
            errors++;
            $display("FAIL perm_events: %0d reset pulses, expected 5", rises);
        end
        checks++;
        if (cause !== 4'b0010) begin
            errors++;
            $display("FAIL perm_cause: cause=%b, expected 0010", cause);
        end
        for (int i = 0; i < HOLD + TO + 4 && busy === 1'b1; i++) tick('0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || viol_cnt !== exp_cnt()) begin
            errors++;
            $display("FAIL perm_release: busy=%b viol_cnt=%0d, expected 0 %0d", busy, viol_cnt, exp_cnt());
        end
    endtask

    task automatic test_clr_collision();
        do_reset();
        tick(4'b0001, 1'b0, 1'b0);
        repeat (HOLD + 1) tick('0, 1'b0, 1'b0);
        checks++;
        if (cause !== 4'b0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_setup: cause=%b busy=%b, expected 0001 0", cause, busy);
        end
        tick(4'b1000, 1'b1, 1'b0);
        checks++;
        if (cause !== 4'b1000 || sys_reset !== 1'b1) begin
            errors++;
            $display("FAIL clr_collision: cause=%b sys_reset=%b, expected 1000 1", cause, sys_reset);
        end
        repeat (HOLD + 1) tick('0, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b0);
        checks++;
        if (cause !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone: cause=%b busy=%b, expected 0000 0", cause, busy);
        end
    endtask

    task automatic test_rst_mid_assert();
        int n_hi;
        do_reset();
        tick(4'b0100, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
        checks++;
        if (cause !== 4'b0100 || sys_reset !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup: cause=%b sys_reset=%b, expected 0100 1", cause, sys_reset);
        end
        tick('0, 1'b0, 1'b1);
        checks++;
        if (sys_reset !== 1'b1 || busy !== 1'b1 || cause !== '0 || viol_cnt !== '0) begin
            errors++;
            $display("FAIL rstmid_values: sys_reset=%b busy=%b cause=%b viol_cnt=%0d, expected 1 1 0000 0",
                     sys_reset, busy, cause, viol_cnt);
        end
        n_hi = 1;
        repeat (HOLD + 1) begin
            tick('0, 1'b0, 1'b0);
            n_hi += int'(sys_reset);
        end
        checks++;
        if (n_hi != HOLD || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_restart: high %0d cycles busy=%b, expected %0d 0", n_hi, busy, HOLD);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        int held;
        v = '0;
        held = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (held > 0) held--;
            else begin
                v = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                held = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 80)) : int'($urandom_range(0, 2));
            end
            tick(v, $urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0);
            checks++;
            if (sys_reset !== exp_sys() || busy !== exp_busy() || cause !== m_cause || viol_cnt !== exp_cnt()) begin
                errors++;
                $display("FAIL random cycle %0d: sys_reset=%b busy=%b cause=%b cnt=%0d, expected %b %b %b %0d",
                         i, sys_reset, busy, cause, viol_cnt, exp_sys(), exp_busy(), m_cause, exp_cnt());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_hold();
        test_permanent();
        test_clr_collision();
        test_rst_mid_assert();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
